lsu: RTL and testbench
======================

# lsu

Load/store unit of the rv32i-pico core, sitting directly upstream of the register file write port. It accepts one decoded load/store per handshake and computes the effective address from the base register value and the immediate. It runs the access on a single valid/ready data-memory port. For loads, it drives the aligned, extended result onto the register file's write select/data lines for exactly one cycle.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_base  in  32  rs1 value
- req_imm  in  12  signed offset
- req_wdata  in  32  rs2 value (stores)
- req_rd  in  5  destination register (loads)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion, sampled only while mem_valid=1
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  replicated store data
- mem_wstrb  out  4  byte enables, 0000 for loads
- mem_rdata  in  32  load data, valid in the mem_ready cycle
- wb_en  out  1  writeback strobe
- wb_select  out  5  to register file write select
- wb_data  out  32  to register file write data
- err  out  1  one-cycle illegal/misaligned pulse

## Operation
- Address: ea = req_base + sign-extend(req_imm), modulo 2^32. ea and all request fields are latched on accept.
- Address wrap: 0xFFFFFFFF + 1 gives 0x00000000.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Store funct3: 000 SB, 001 SH, 010 SW.
- Any other funct3: err pulse, no bus access, no writeback.
- Store strobes:
  - SB: wstrb = 0001 << ea[1:0]; wdata = {4{d[7:0]}}
  - SH: wstrb = 0011 << {ea[1],0}; wdata = {2{d[15:0]}}
  - SW: wstrb = 1111; wdata = d
- Loads select the byte or halfword from mem_rdata by ea[1:0] (halfword by ea[1]), then sign- or zero-extend.
- The register file has no write enable. When wb_en=0, wb_select and wb_data are driven to 0, so every cycle writes to register 0, which has no storage.
- A load with rd=0 still performs its bus access. wb_en pulses with wb_select=0.
- States:
  - IDLE: req_ready=1. On accept, go to MEM, or to ERR if illegal or trapped.
  - MEM: mem_valid=1. On mem_ready, a store goes to IDLE and a load goes to WB.
  - WB: wb_en=1 with the latched rd and data, then go to IDLE.
  - ERR: err=1, then go to IDLE.

## Timing
- Reset values (asserted at any time, including mid-transaction):
  - state=IDLE
  - req_ready=1
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0
  - wb_en=0, wb_select=0, wb_data=0
  - err=0
- An in-flight bus transaction is abandoned on reset; a late mem_ready is ignored.
- Accept at edge N. mem_valid rises in cycle N+1.
- mem_addr, mem_wdata and mem_wstrb are stable from N+1 until the mem_ready edge.
- Zero-wait load (mem_ready in N+1): wb_en in N+2, req_ready=1 in N+3. Total latency 3 cycles.
- Zero-wait store: req_ready=1 in N+2.
- Each wait cycle adds one cycle.
- ERR path: err=1 in N+1, req_ready=1 in N+2.
- req_ready is 0 in every state except IDLE. There is no back-to-back overlap.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misalignment means LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]!=0.
  - A misaligned request goes to ERR: err pulse, no bus access, no writeback.
- Undefined:
  - Misalignment is not detected.
  - Halfword accesses ignore ea[0]; word accesses ignore ea[1:0].
  - The access proceeds as if aligned.
- The illegal-funct3 err applies in both builds.

## Test plan
- LB: base 0x100, imm 0x003, rd 5, mem_rdata 0x80FF0000, zero wait → mem_addr 0x100, wb_en with wb_select 5, wb_data 0xFFFFFF80, three cycles after accept. Repeat as LBU → wb_data 0x00000080.
- SH: base 0x200, imm -2 (0xFFE), rs2 0x1234ABCD → mem_addr 0x1FC, mem_wstrb 1100, mem_wdata 0xABCDABCD, no wb_en, req_ready high two cycles after accept.
- LW at 0x40 with mem_ready delayed 3 cycles → mem_valid/mem_addr held constant for 4 cycles, single wb_en pulse, wb_select=0 in every other cycle.
- LW at ea 0x42: with LSU_MISALIGN_TRAP_EN → err for one cycle, mem_valid never rises. Without it → mem_addr 0x40, normal writeback.
- funct3=011 load → err pulse. Reset driven low during MEM → mem_valid=0 immediately, req_ready=1 after release, later mem_ready causes no writeback.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit for the rv32i-pico core: one request per handshake, single valid/ready memory port, one-cycle writeback.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into err pulses.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_imm,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_select,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_req_ready;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_wb_en;
  logic [4:0]  r_wb_select;
  logic [31:0] r_wb_data;
  logic        r_err;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_ea_lo;
  logic [4:0]  r_rd;

  logic [31:0] w_ea;
  logic        w_accept;
  logic        w_legal;
  logic        w_misalign;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata_rep;

  // Select the addressed byte/halfword of a load word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h000000, b};
      3'b101:  load_ext = {16'h0000, h};
      default: load_ext = d;
    endcase
  endfunction

  assign w_ea     = req_base + {{20{req_imm[11]}}, req_imm};
  assign w_accept = req_valid && r_req_ready;

  // Decode legality, misalignment and store lane data for the incoming request.
  always_comb begin
    w_legal     = 1'b0;
    w_misalign  = 1'b0;
    w_strb      = 4'b0000;
    w_wdata_rep = 32'h0000_0000;
    case (req_funct3)
      3'b000: begin
        w_legal     = 1'b1;
        w_strb      = req_is_store ? (4'b0001 << w_ea[1:0]) : 4'b0000;
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        w_legal     = 1'b1;
        w_strb      = req_is_store ? (w_ea[1] ? 4'b1100 : 4'b0011) : 4'b0000;
        w_wdata_rep = {2{req_wdata[15:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign  = w_ea[0];
`else
        w_misalign  = 1'b0;
`endif
      end
      3'b010: begin
        w_legal     = 1'b1;
        w_strb      = req_is_store ? 4'b1111 : 4'b0000;
        w_wdata_rep = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign  = (w_ea[1:0] != 2'b00);
`else
        w_misalign  = 1'b0;
`endif
      end
      3'b100, 3'b101: begin
        w_legal     = !req_is_store;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign  = (req_funct3 == 3'b101) && w_ea[0];
`else
        w_misalign  = 1'b0;
`endif
      end
      default: begin
        w_legal     = 1'b0;
        w_misalign  = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal || w_misalign) w_next = S_ERR;
          else                        w_next = S_MEM;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MEM: begin
        if (mem_ready) w_next = r_is_store ? S_IDLE : S_WB;
        else           w_next = S_MEM;
      end
      S_WB:    w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and registered control outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_wb_en     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == S_IDLE);
      r_mem_valid <= (w_next == S_MEM);
      r_wb_en     <= (w_next == S_WB);
      r_err       <= (w_next == S_ERR);
    end
  end

  // Request latch and bus drive: held through MEM, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_ea_lo     <= 2'b00;
      r_rd        <= 5'd0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_is_store  <= req_is_store;
      r_funct3    <= req_funct3;
      r_ea_lo     <= w_ea[1:0];
      r_rd        <= req_rd;
      r_mem_addr  <= (w_next == S_MEM) ? {w_ea[31:2], 2'b00} : 32'h0000_0000;
      r_mem_wdata <= (w_next == S_MEM && req_is_store) ? w_wdata_rep : 32'h0000_0000;
      r_mem_wstrb <= (w_next == S_MEM) ? w_strb : 4'b0000;
    end else if (w_next != S_MEM) begin
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
    end else begin
      r_mem_addr  <= r_mem_addr;
      r_mem_wdata <= r_mem_wdata;
      r_mem_wstrb <= r_mem_wstrb;
    end
  end

  // Writeback lines: select/data are zero whenever wb_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_select <= 5'd0;
      r_wb_data   <= 32'h0000_0000;
    end else if (r_state == S_MEM && w_next == S_WB) begin
      r_wb_select <= r_rd;
      r_wb_data   <= load_ext(r_funct3, r_ea_lo, mem_rdata);
    end else begin
      r_wb_select <= 5'd0;
      r_wb_data   <= 32'h0000_0000;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign wb_en     = r_wb_en;
  assign wb_select = r_wb_select;
  assign wb_data   = r_wb_data;
  assign err       = r_err;

endmodule

// File: tb/tb_lsu.sv
// Table-driven bench for lsu with an expected-result queue; vectors follow the build macro LSU_MISALIGN_TRAP_EN.
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_select;
  logic [31:0] wb_data;
  logic        err;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;
    logic        e_err;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_wbdata;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_imm(req_imm), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_select(wb_select), .wb_data(wb_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                              input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] rdata, input int waits, input logic e_err,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input logic [31:0] e_wbdata);
    vec_t v;
    v.is_store = st; v.f3 = f3; v.base = base; v.imm = imm; v.wdata = wd; v.rd = rd;
    v.rdata = rdata; v.waits = waits; v.e_err = e_err; v.e_addr = e_addr; v.e_strb = e_strb;
    v.e_wdata = e_wdata; v.e_wbdata = e_wbdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    logic [31:0] addr0;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = v.is_store; req_funct3 = v.f3; req_base = v.base;
    req_imm = v.imm; req_wdata = v.wdata; req_rd = v.rd;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_base = 32'hFFFF_FFFF; req_imm = 12'h000; req_wdata = 32'h0000_0000;
    chk($sformatf("v%0d ready_busy", idx), {31'd0, req_ready}, 32'd0);
    if (v.e_err) begin
      chk($sformatf("v%0d err", idx), {31'd0, err}, 32'd1);
      chk($sformatf("v%0d err_no_bus", idx), {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d err_once", idx), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d err_ready", idx), {31'd0, req_ready}, 32'd1);
      chk($sformatf("v%0d err_no_wb", idx), {31'd0, wb_en}, 32'd0);
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else e = sb.pop_front();
      return;
    end
    addr0 = mem_addr;
    for (int k = 0; k <= v.waits; k++) begin
      chk($sformatf("v%0d mem_valid c%0d", idx, k), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("v%0d addr c%0d", idx, k), mem_addr, v.e_addr);
      chk($sformatf("v%0d no_wbsel c%0d", idx, k), {26'd0, wb_en, wb_select}, 32'd0);
      chk($sformatf("v%0d no_err c%0d", idx, k), {31'd0, err}, 32'd0);
      if (k == 0) begin
        chk($sformatf("v%0d wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.e_strb});
        if (v.is_store) chk($sformatf("v%0d wdata", idx), mem_wdata, v.e_wdata);
      end
      mem_ready = (k == v.waits);
      mem_rdata = (k == v.waits) ? v.rdata : 32'hDEAD_0000;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0000_0000;
    chk($sformatf("v%0d bus_done", idx), {31'd0, mem_valid}, 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.is_store) begin
      chk($sformatf("v%0d st_no_wb", idx), {31'd0, wb_en}, 32'd0);
      chk($sformatf("v%0d st_ready", idx), {31'd0, req_ready}, 32'd1);
    end else begin
      chk($sformatf("v%0d wb_en", idx), {31'd0, wb_en}, 32'd1);
      chk($sformatf("v%0d wb_select", idx), {27'd0, wb_select}, {27'd0, e.rd});
      chk($sformatf("v%0d wb_data", idx), wb_data, e.e_wbdata);
      chk($sformatf("v%0d wb_busy", idx), {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d wb_once", idx), {31'd0, wb_en}, 32'd0);
      chk($sformatf("v%0d wb_zero", idx), {27'd0, wb_select} | wb_data, 32'd0);
      chk($sformatf("v%0d ld_ready", idx), {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_base = 32'h0; req_imm = 12'h000; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    vecs[0]  = mk(1'b0, 3'b000, 32'h100, 12'h003, 32'h0, 5'd5, 32'h80FF0000, 0, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80);
    vecs[1]  = mk(1'b0, 3'b100, 32'h100, 12'h003, 32'h0, 5'd5, 32'h80FF0000, 0, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h00000080);
    vecs[2]  = mk(1'b1, 3'b001, 32'h200, 12'hFFE, 32'h1234ABCD, 5'd0, 32'h0, 0, 1'b0, 32'h1FC, 4'b1100, 32'hABCDABCD, 32'h0);
    vecs[3]  = mk(1'b0, 3'b010, 32'h40, 12'h000, 32'h0, 5'd7, 32'hDEADBEEF, 3, 1'b0, 32'h40, 4'b0000, 32'h0, 32'hDEADBEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[4]  = mk(1'b0, 3'b010, 32'h40, 12'h002, 32'h0, 5'd9, 32'h11223344, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[15] = mk(1'b1, 3'b001, 32'h301, 12'h000, 32'h5555AAAA, 5'd0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
`else
    vecs[4]  = mk(1'b0, 3'b010, 32'h40, 12'h002, 32'h0, 5'd9, 32'h11223344, 0, 1'b0, 32'h40, 4'b0000, 32'h0, 32'h11223344);
    vecs[15] = mk(1'b1, 3'b001, 32'h301, 12'h000, 32'h5555AAAA, 5'd0, 32'h0, 0, 1'b0, 32'h300, 4'b0011, 32'hAAAAAAAA, 32'h0);
`endif
    vecs[5]  = mk(1'b0, 3'b011, 32'h40, 12'h000, 32'h0, 5'd4, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[6]  = mk(1'b1, 3'b000, 32'hFFFFFFFF, 12'h001, 32'h000000A5, 5'd0, 32'h0, 0, 1'b0, 32'h0, 4'b0001, 32'hA5A5A5A5, 32'h0);
    vecs[7]  = mk(1'b0, 3'b001, 32'h300, 12'h002, 32'h0, 5'd3, 32'h80011234, 0, 1'b0, 32'h300, 4'b0000, 32'h0, 32'hFFFF8001);
    vecs[8]  = mk(1'b0, 3'b101, 32'h300, 12'h002, 32'h0, 5'd3, 32'h80011234, 1, 1'b0, 32'h300, 4'b0000, 32'h0, 32'h00008001);
    vecs[9]  = mk(1'b1, 3'b010, 32'h10, 12'h7FC, 32'hCAFEF00D, 5'd0, 32'h0, 1, 1'b0, 32'h80C, 4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[10] = mk(1'b0, 3'b010, 32'h20, 12'h000, 32'h0, 5'd0, 32'h55AA55AA, 0, 1'b0, 32'h20, 4'b0000, 32'h0, 32'h55AA55AA);
    vecs[11] = mk(1'b1, 3'b011, 32'h20, 12'h000, 32'h0, 5'd0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[12] = mk(1'b1, 3'b000, 32'h0, 12'h002, 32'h00000011, 5'd0, 32'h0, 0, 1'b0, 32'h0, 4'b0100, 32'h11111111, 32'h0);
    vecs[13] = mk(1'b0, 3'b000, 32'h100, 12'h001, 32'h0, 5'd12, 32'h00007F00, 2, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h0000007F);
    vecs[14] = mk(1'b0, 3'b010, 32'h1000, 12'h800, 32'h0, 5'd31, 32'h0BADF00D, 0, 1'b0, 32'h800, 4'b0000, 32'h0, 32'h0BADF00D);

    #12;
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst mem", {31'd0, mem_valid} | mem_addr | mem_wdata | {28'd0, mem_wstrb}, 32'd0);
    chk("rst wb", {31'd0, wb_en} | {27'd0, wb_select} | wb_data | {31'd0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset while a load sits in MEM; a late mem_ready must not produce a writeback.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h40; req_imm = 12'h000; req_rd = 5'd6;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mr mem_valid", {31'd0, mem_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr valid_drop", {31'd0, mem_valid}, 32'd0);
    chk("mr addr_clr", mem_addr, 32'd0);
    chk("mr ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mr no_wb c%0d", c), {31'd0, wb_en} | {27'd0, wb_select} | wb_data, 32'd0);
      chk($sformatf("mr idle c%0d", c), {31'd0, req_ready}, 32'd1);
      chk($sformatf("mr no_bus c%0d", c), {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
    end
    chk("sb drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
